// File: rtl/jimmy_io_sequencer_if.sv
// jimmy_io_sequencer_if
//   Bundles the host-side and CPU-side signals of the jimmy I/O sequencer.
//   slave  : used by the sequencer itself.
//   master : used by whatever drives the sequencer (host logic, CPU shim, bench).
//   Signals:
//     host_wr_valid/host_wr_data/host_wr_ready : push into the input FIFO
//     host_start/host_expected/host_clear      : run control pulses
//     host_rd_valid/host_rd_data/host_rd_ready : pop from the output FIFO
//     cpu_reset                                : active-low reset to the CPU
//     cpu_in_strobe/cpu_in_port                : CPU in_port_0 path
//     cpu_out_strobe/cpu_out_port              : CPU out_port_0 path
//     state/underflow/overflow                 : status
//   Optional macro JIMMY_IO_STATS_EN adds run_cycles and in_consumed.
interface jimmy_io_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              host_wr_valid;
    logic [DATA_W-1:0] host_wr_data;
    logic              host_wr_ready;
    logic              host_start;
    logic [7:0]        host_expected;
    logic              host_clear;
    logic              host_rd_valid;
    logic [DATA_W-1:0] host_rd_data;
    logic              host_rd_ready;
    logic              cpu_reset;
    logic              cpu_in_strobe;
    logic [DATA_W-1:0] cpu_in_port;
    logic              cpu_out_strobe;
    logic [DATA_W-1:0] cpu_out_port;
    logic [1:0]        state;
    logic              underflow;
    logic              overflow;
`ifdef JIMMY_IO_STATS_EN
    logic [15:0]       run_cycles;
    logic [7:0]        in_consumed;
`endif

    modport slave (
        input  host_wr_valid, host_wr_data, host_start, host_expected,
               host_clear, host_rd_ready, cpu_in_strobe, cpu_out_strobe,
               cpu_out_port,
        output host_wr_ready, host_rd_valid, host_rd_data, cpu_reset,
               cpu_in_port, state, underflow, overflow
`ifdef JIMMY_IO_STATS_EN
      , output run_cycles, in_consumed
`endif
    );

    modport master (
        output host_wr_valid, host_wr_data, host_start, host_expected,
               host_clear, host_rd_ready, cpu_in_strobe, cpu_out_strobe,
               cpu_out_port,
        input  host_wr_ready, host_rd_valid, host_rd_data, cpu_reset,
               cpu_in_port, state, underflow, overflow
`ifdef JIMMY_IO_STATS_EN
      , input  run_cycles, in_consumed
`endif
    );
endinterface

// File: rtl/jimmy_io_sequencer.sv
// jimmy_io_sequencer
//   Runs the jimmy CPU against port 0: holds the CPU in reset while the host
//   preloads the input FIFO, releases it on host_start, feeds in_port_0 from
//   the input FIFO and captures out_port_0 into the output FIFO, and ends the
//   run after host_expected outputs (DONE) or RUN_TIMEOUT cycles (TIMEOUT).
//   Ports:
//     clk   : system clock
//     reset : asynchronous active-low reset
//     bus   : jimmy_io_sequencer_if.slave (host and CPU port-0 signals)
//   Optional macro JIMMY_IO_STATS_EN adds run_cycles (RUN length, saturating
//   at 0xFFFF) and in_consumed (successful input pops this run).
module jimmy_io_sequencer #(
    parameter int DEPTH       = 16,
    parameter int DATA_W      = 8,
    parameter int RUN_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    jimmy_io_sequencer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'b00,
        ST_RUN     = 2'b01,
        ST_DONE    = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic [PW-1:0]     in_wp_q, in_wp_d, in_rp_q, in_rp_d;
    logic [PW-1:0]     out_wp_q, out_wp_d, out_rp_q, out_rp_d;
    logic              in_prev_q, out_prev_q;
    logic              underflow_q, underflow_d, overflow_q, overflow_d;
    logic [7:0]        expected_q, expected_d;
    logic [7:0]        out_cnt_q, out_cnt_d;
    logic [31:0]       run_cnt_q, run_cnt_d;
    logic [DATA_W-1:0] in_mem_q  [DEPTH];
    logic [DATA_W-1:0] out_mem_q [DEPTH];

    logic in_empty, in_full, out_empty, out_full;
    logic running, can_write;
    logic in_push, in_edge, in_pop;
    logic out_edge, out_pop, out_push;
    logic done_hit, to_hit;
    logic [7:0] out_cnt_inc;

    // Full/empty: equal index bits, MSB differs for full.
    assign in_empty  = (in_wp_q == in_rp_q);
    assign in_full   = (in_wp_q[AW] != in_rp_q[AW]) &&
                       (in_wp_q[AW-1:0] == in_rp_q[AW-1:0]);
    assign out_empty = (out_wp_q == out_rp_q);
    assign out_full  = (out_wp_q[AW] != out_rp_q[AW]) &&
                       (out_wp_q[AW-1:0] == out_rp_q[AW-1:0]);

    assign running   = (state_q == ST_RUN);
    assign can_write = (state_q == ST_LOAD) || (state_q == ST_RUN);

    // Falling strobe edge is where the CPU consumes/produces the value.
    assign in_push  = bus.host_wr_valid && can_write && !in_full;
    assign in_edge  = running && in_prev_q && !bus.cpu_in_strobe;
    assign in_pop   = in_edge && !in_empty;
    assign out_edge = running && out_prev_q && !bus.cpu_out_strobe;
    assign out_pop  = !out_empty && bus.host_rd_ready;
    // A same-cycle host pop frees the slot the capture needs.
    assign out_push = out_edge && (!out_full || out_pop);

    assign out_cnt_inc = out_cnt_q + 8'd1;
    assign done_hit    = out_edge && (expected_q != 8'd0) && (out_cnt_inc == expected_q);
    assign to_hit      = running && (run_cnt_q == 32'(RUN_TIMEOUT - 1));

`ifdef JIMMY_IO_STATS_EN
    logic [15:0] run_cycles_q, run_cycles_d;
    logic [7:0]  in_consumed_q, in_consumed_d;

    function automatic logic [15:0] sat16(input logic [31:0] v);
        return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        in_wp_d     = in_wp_q  + (in_push  ? PW'(1) : PW'(0));
        in_rp_d     = in_rp_q  + (in_pop   ? PW'(1) : PW'(0));
        out_wp_d    = out_wp_q + (out_push ? PW'(1) : PW'(0));
        out_rp_d    = out_rp_q + (out_pop  ? PW'(1) : PW'(0));
        underflow_d = underflow_q || (in_edge && in_empty);
        overflow_d  = overflow_q  || (out_edge && !out_push);
        expected_d  = expected_q;
        out_cnt_d   = out_cnt_q;
        run_cnt_d   = run_cnt_q;
`ifdef JIMMY_IO_STATS_EN
        run_cycles_d  = run_cycles_q;
        in_consumed_d = in_consumed_q + (in_pop ? 8'd1 : 8'd0);
`endif
        case (state_q)
            ST_LOAD: begin
                if (bus.host_start) begin
                    state_d    = ST_RUN;
                    expected_d = bus.host_expected;
                    out_cnt_d  = 8'd0;
                    run_cnt_d  = 32'd0;
`ifdef JIMMY_IO_STATS_EN
                    in_consumed_d = 8'd0;
`endif
                end
            end
            ST_RUN: begin
                run_cnt_d = run_cnt_q + 32'd1;
                if (out_edge) out_cnt_d = out_cnt_inc;
                // DONE takes priority over a coincident timeout.
                if (done_hit)    state_d = ST_DONE;
                else if (to_hit) state_d = ST_TIMEOUT;
`ifdef JIMMY_IO_STATS_EN
                if (done_hit || to_hit) run_cycles_d = sat16(run_cnt_q + 32'd1);
`endif
            end
            default: begin
                if (bus.host_clear) begin
                    state_d     = ST_LOAD;
                    in_wp_d     = '0;
                    in_rp_d     = '0;
                    out_wp_d    = '0;
                    out_rp_d    = '0;
                    underflow_d = 1'b0;
                    overflow_d  = 1'b0;
`ifdef JIMMY_IO_STATS_EN
                    run_cycles_d  = 16'd0;
                    in_consumed_d = 8'd0;
`endif
                end
            end
        endcase
        cpu_reset_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_LOAD;
            cpu_reset_q <= 1'b0;
            in_wp_q     <= '0;
            in_rp_q     <= '0;
            out_wp_q    <= '0;
            out_rp_q    <= '0;
            in_prev_q   <= 1'b0;
            out_prev_q  <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            expected_q  <= 8'd0;
            out_cnt_q   <= 8'd0;
            run_cnt_q   <= 32'd0;
`ifdef JIMMY_IO_STATS_EN
            run_cycles_q  <= 16'd0;
            in_consumed_q <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cpu_reset_q <= cpu_reset_d;
            in_wp_q     <= in_wp_d;
            in_rp_q     <= in_rp_d;
            out_wp_q    <= out_wp_d;
            out_rp_q    <= out_rp_d;
            in_prev_q   <= bus.cpu_in_strobe;
            out_prev_q  <= bus.cpu_out_strobe;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            expected_q  <= expected_d;
            out_cnt_q   <= out_cnt_d;
            run_cnt_q   <= run_cnt_d;
`ifdef JIMMY_IO_STATS_EN
            run_cycles_q  <= run_cycles_d;
            in_consumed_q <= in_consumed_d;
`endif
        end
    end

    // FIFO storage carries data only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (in_push)  in_mem_q[in_wp_q[AW-1:0]]   <= bus.host_wr_data;
        if (out_push) out_mem_q[out_wp_q[AW-1:0]] <= bus.cpu_out_port;
    end

    assign bus.state         = state_q;
    assign bus.cpu_reset     = cpu_reset_q;
    assign bus.underflow     = underflow_q;
    assign bus.overflow      = overflow_q;
    assign bus.host_wr_ready = can_write && !in_full;
    assign bus.host_rd_valid = !out_empty;
    assign bus.host_rd_data  = out_empty ? '0 : out_mem_q[out_rp_q[AW-1:0]];
    assign bus.cpu_in_port   = in_empty  ? '0 : in_mem_q[in_rp_q[AW-1:0]];
`ifdef JIMMY_IO_STATS_EN
    assign bus.run_cycles    = run_cycles_q;
    assign bus.in_consumed   = in_consumed_q;
`endif
endmodule

// File: tb/tb_jimmy_io_sequencer.sv
module tb_jimmy_io_sequencer;
    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int TO    = 128;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   n;
    int   run_seen;

    jimmy_io_sequencer_if #(.DATA_W(DW)) ifc ();

    jimmy_io_sequencer #(.DEPTH(DEPTH), .DATA_W(DW), .RUN_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial run_seen = 0;
    always @(negedge clk) if (ifc.state == 2'b01) run_seen <= run_seen + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe_in;
        ifc.cpu_in_strobe = 1'b1;
        tick;
        ifc.cpu_in_strobe = 1'b0;
        tick;
    endtask

    task automatic strobe_out(input logic [DW-1:0] v);
        ifc.cpu_out_port   = v;
        ifc.cpu_out_strobe = 1'b1;
        tick;
        ifc.cpu_out_strobe = 1'b0;
        tick;
    endtask

    task automatic push(input logic [DW-1:0] v);
        ifc.host_wr_valid = 1'b1;
        ifc.host_wr_data  = v;
        tick;
        ifc.host_wr_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] exp_n);
        ifc.host_expected = exp_n;
        ifc.host_start    = 1'b1;
        tick;
        ifc.host_start    = 1'b0;
    endtask

    task automatic pulse_clear;
        ifc.host_clear = 1'b1;
        tick;
        ifc.host_clear = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        ifc.host_wr_valid  = 1'b0;
        ifc.host_wr_data   = '0;
        ifc.host_start     = 1'b0;
        ifc.host_expected  = 8'd0;
        ifc.host_clear     = 1'b0;
        ifc.host_rd_ready  = 1'b0;
        ifc.cpu_in_strobe  = 1'b0;
        ifc.cpu_out_strobe = 1'b0;
        ifc.cpu_out_port   = '0;
        tick;
        tick;
        check("rst_state",    32'(ifc.state), 32'd0);
        check("rst_cpu_reset", 32'(ifc.cpu_reset), 32'd0);
        check("rst_rd_valid", 32'(ifc.host_rd_valid), 32'd0);
        check("rst_in_port",  32'(ifc.cpu_in_port), 32'd0);
        check("rst_flags",    32'({ifc.underflow, ifc.overflow}), 32'd0);
        check("rst_wr_ready", 32'(ifc.host_wr_ready), 32'd1);
        reset = 1'b1;
        tick;

        // Scenario 1: preload, feed, capture two outputs, DONE.
        push(8'd5);
        push(8'd3);
        push(8'd4);
        check("load_head", 32'(ifc.cpu_in_port), 32'd5);
        check("load_cpu_reset", 32'(ifc.cpu_reset), 32'd0);
        pulse_start(8'd2);
        check("s1_state_run", 32'(ifc.state), 32'd1);
        check("s1_cpu_reset", 32'(ifc.cpu_reset), 32'd1);
        check("s1_in0", 32'(ifc.cpu_in_port), 32'd5);
        strobe_in;
        check("s1_in1", 32'(ifc.cpu_in_port), 32'd3);
        strobe_in;
        check("s1_in2", 32'(ifc.cpu_in_port), 32'd4);
        strobe_in;
        check("s1_in_empty", 32'(ifc.cpu_in_port), 32'd0);
        check("s1_no_underflow", 32'(ifc.underflow), 32'd0);
        strobe_out(8'd8);
        check("s1_run_after_1", 32'(ifc.state), 32'd1);
        check("s1_rd_valid", 32'(ifc.host_rd_valid), 32'd1);
        strobe_out(8'd9);
        check("s1_done", 32'(ifc.state), 32'd2);
        check("s1_done_cpu_reset", 32'(ifc.cpu_reset), 32'd0);
        check("s1_done_wr_ready", 32'(ifc.host_wr_ready), 32'd0);
`ifdef JIMMY_IO_STATS_EN
        check("s6_in_consumed", 32'(ifc.in_consumed), 32'd3);
        check("s6_run_cycles", 32'(ifc.run_cycles), 32'(run_seen));
`endif
        check("s1_rd0", 32'(ifc.host_rd_data), 32'd8);
        ifc.host_rd_ready = 1'b1;
        tick;
        check("s1_rd1", 32'(ifc.host_rd_data), 32'd9);
        tick;
        ifc.host_rd_ready = 1'b0;
        check("s1_rd_empty", 32'(ifc.host_rd_valid), 32'd0);
        pulse_clear;
        check("s1_clear_state", 32'(ifc.state), 32'd0);

        // Scenarios 2 and 3: underflow on empty input, then timeout.
        pulse_start(8'd0);
        n = 0;
        check("s2_state_run", 32'(ifc.state), 32'd1);
        strobe_in;
        n += 2;
        check("s2_underflow", 32'(ifc.underflow), 32'd1);
        check("s2_in_port", 32'(ifc.cpu_in_port), 32'd0);
        check("s2_still_run", 32'(ifc.state), 32'd1);
        while (ifc.state == 2'b01 && n < TO + 8) begin
            tick;
            n++;
        end
        check("s3_timeout_cycles", 32'(n), 32'(TO));
        check("s3_timeout_state", 32'(ifc.state), 32'd3);
        check("s3_cpu_reset", 32'(ifc.cpu_reset), 32'd0);
        pulse_start(8'd0);
        check("s3_start_ignored", 32'(ifc.state), 32'd3);
        pulse_clear;
        check("s3_clear_state", 32'(ifc.state), 32'd0);
        check("s3_clear_flags", 32'({ifc.underflow, ifc.overflow}), 32'd0);

        // Scenario 4: output FIFO fill, same-cycle pop+capture, overflow.
        pulse_start(8'd0);
        pulse_clear;
        check("s4_clear_ignored", 32'(ifc.state), 32'd1);
        for (int i = 0; i < DEPTH; i++) strobe_out(8'(8'h10 + i));
        check("s4_full_no_ovf", 32'(ifc.overflow), 32'd0);
        check("s4_head", 32'(ifc.host_rd_data), 32'h10);
        ifc.cpu_out_port   = 8'hAA;
        ifc.cpu_out_strobe = 1'b1;
        tick;
        ifc.cpu_out_strobe = 1'b0;
        ifc.host_rd_ready  = 1'b1;
        tick;
        ifc.host_rd_ready  = 1'b0;
        check("s4_pop_capture_no_ovf", 32'(ifc.overflow), 32'd0);
        strobe_out(8'hBB);
        check("s4_overflow", 32'(ifc.overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("s4_rd%0d", i), 32'(ifc.host_rd_data),
                  (i < DEPTH - 1) ? 32'(8'h11 + i) : 32'hAA);
            ifc.host_rd_ready = 1'b1;
            tick;
            ifc.host_rd_ready = 1'b0;
        end
        check("s4_drained", 32'(ifc.host_rd_valid), 32'd0);

        // Scenario 5: asynchronous reset mid-RUN.
        push(8'h77);
        check("s5_in_head", 32'(ifc.cpu_in_port), 32'h77);
        strobe_out(8'h55);
        check("s5_rd_valid", 32'(ifc.host_rd_valid), 32'd1);
        check("s5_cpu_reset_run", 32'(ifc.cpu_reset), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("s5_async_cpu_reset", 32'(ifc.cpu_reset), 32'd0);
        check("s5_async_state", 32'(ifc.state), 32'd0);
        check("s5_async_rd_valid", 32'(ifc.host_rd_valid), 32'd0);
        check("s5_async_in_port", 32'(ifc.cpu_in_port), 32'd0);
        check("s5_async_flags", 32'({ifc.underflow, ifc.overflow}), 32'd0);
        tick;
        reset = 1'b1;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
